// File: rtl/axi4_lite_master_q.sv
// Queued AXI4-Lite master with per-direction command FIFOs and independent read/write engines.
// Optional statistics counters are enabled by defining AXIM_STATS_EN.
module axi4_lite_master_q #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [DATA_W-1:0]   wr_req_data,
  input  logic [DATA_W/8-1:0] wr_req_strb,
  output logic                wr_rsp_valid,
  output logic [1:0]          wr_rsp_resp,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  output logic                rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  output logic [1:0]          rd_rsp_resp,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
`ifdef AXIM_STATS_EN
  , output logic [15:0]       wr_count
  , output logic [15:0]       rd_count
  , output logic [15:0]       err_count
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  logic [ADDR_W-1:0] wf_addr [CMD_DEPTH];
  logic [DATA_W-1:0] wf_data [CMD_DEPTH];
  logic [SW-1:0]     wf_strb [CMD_DEPTH];
  logic [ADDR_W-1:0] rf_addr [CMD_DEPTH];
  logic [PW:0]       wf_wptr, wf_rptr, wf_wptr_n, wf_rptr_n;
  logic [PW:0]       rf_wptr, rf_rptr, rf_wptr_n, rf_rptr_n;
  logic              wf_push, wf_pop, wf_empty, wf_full_n;
  logic              rf_push, rf_pop, rf_empty, rf_full_n;

  // Ready is registered from the post-update pointers, so it reflects this cycle's push/pop.
  assign wf_push   = wr_req_valid && wr_req_ready;
  assign rf_push   = rd_req_valid && rd_req_ready;
  assign wf_empty  = (wf_wptr == wf_rptr);
  assign rf_empty  = (rf_wptr == rf_rptr);
  assign wf_wptr_n = wf_wptr + (PW+1)'(wf_push);
  assign wf_rptr_n = wf_rptr + (PW+1)'(wf_pop);
  assign rf_wptr_n = rf_wptr + (PW+1)'(rf_push);
  assign rf_rptr_n = rf_rptr + (PW+1)'(rf_pop);
  assign wf_full_n = (wf_wptr_n[PW] != wf_rptr_n[PW]) && (wf_wptr_n[PW-1:0] == wf_rptr_n[PW-1:0]);
  assign rf_full_n = (rf_wptr_n[PW] != rf_rptr_n[PW]) && (rf_wptr_n[PW-1:0] == rf_rptr_n[PW-1:0]);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wf_wptr      <= '0;
      wf_rptr      <= '0;
      rf_wptr      <= '0;
      rf_rptr      <= '0;
      wr_req_ready <= 1'b0;
      rd_req_ready <= 1'b0;
    end else begin
      wf_wptr      <= wf_wptr_n;
      wf_rptr      <= wf_rptr_n;
      rf_wptr      <= rf_wptr_n;
      rf_rptr      <= rf_rptr_n;
      wr_req_ready <= !wf_full_n;
      rd_req_ready <= !rf_full_n;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wf_push) begin
      wf_addr[wf_wptr[PW-1:0]] <= wr_req_addr;
      wf_data[wf_wptr[PW-1:0]] <= wr_req_data;
      wf_strb[wf_wptr[PW-1:0]] <= wr_req_strb;
    end
    if (rf_push) rf_addr[rf_wptr[PW-1:0]] <= rd_req_addr;
  end

  // Write engine
  w_state_t    w_state, w_state_n;
  logic        aw_pend, w_pend;
  logic        awvalid_d, wvalid_d, bready_d, wr_rsp_valid_d;
  logic [1:0]  wr_rsp_resp_d;

  assign aw_pend = AWVALID && !AWREADY;
  assign w_pend  = WVALID && !WREADY;

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (!wf_empty) w_state_n = W_SEND;
      W_SEND:  if (!aw_pend && !w_pend) w_state_n = W_RESP;
      W_RESP:  if (BVALID && BREADY) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    wf_pop         = 1'b0;
    awvalid_d      = AWVALID;
    wvalid_d       = WVALID;
    bready_d       = BREADY;
    wr_rsp_valid_d = 1'b0;
    wr_rsp_resp_d  = wr_rsp_resp;
    case (w_state)
      W_IDLE: if (!wf_empty) begin
        wf_pop    = 1'b1;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end
      W_SEND: begin
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) bready_d = 1'b1;
      end
      W_RESP: if (BVALID && BREADY) begin
        wr_rsp_valid_d = 1'b1;
        wr_rsp_resp_d  = BRESP;
        bready_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state      <= W_IDLE;
      AWVALID      <= 1'b0;
      WVALID       <= 1'b0;
      BREADY       <= 1'b0;
      AWADDR       <= '0;
      WDATA        <= '0;
      WSTRB        <= '0;
      wr_rsp_valid <= 1'b0;
      wr_rsp_resp  <= 2'b00;
    end else begin
      w_state      <= w_state_n;
      AWVALID      <= awvalid_d;
      WVALID       <= wvalid_d;
      BREADY       <= bready_d;
      wr_rsp_valid <= wr_rsp_valid_d;
      wr_rsp_resp  <= wr_rsp_resp_d;
      if (wf_pop) begin
        AWADDR <= wf_addr[wf_rptr[PW-1:0]];
        WDATA  <= wf_data[wf_rptr[PW-1:0]];
        WSTRB  <= wf_strb[wf_rptr[PW-1:0]];
      end
    end
  end

  // Read engine
  r_state_t    r_state, r_state_n;
  logic        arvalid_d, rready_d, rd_rsp_valid_d;
  logic [1:0]  rd_rsp_resp_d;
  logic [DATA_W-1:0] rd_rsp_data_d;

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (!rf_empty) r_state_n = R_ADDR;
      R_ADDR:  if (ARREADY) r_state_n = R_DATA;
      R_DATA:  if (RVALID && RREADY) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    rf_pop         = 1'b0;
    arvalid_d      = ARVALID;
    rready_d       = RREADY;
    rd_rsp_valid_d = 1'b0;
    rd_rsp_resp_d  = rd_rsp_resp;
    rd_rsp_data_d  = rd_rsp_data;
    case (r_state)
      R_IDLE: if (!rf_empty) begin
        rf_pop    = 1'b1;
        arvalid_d = 1'b1;
      end
      R_ADDR: if (ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      R_DATA: if (RVALID && RREADY) begin
        rd_rsp_valid_d = 1'b1;
        rd_rsp_resp_d  = RRESP;
        rd_rsp_data_d  = RDATA;
        rready_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= R_IDLE;
      ARVALID      <= 1'b0;
      ARADDR       <= '0;
      RREADY       <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_resp  <= 2'b00;
      rd_rsp_data  <= '0;
    end else begin
      r_state      <= r_state_n;
      ARVALID      <= arvalid_d;
      RREADY       <= rready_d;
      rd_rsp_valid <= rd_rsp_valid_d;
      rd_rsp_resp  <= rd_rsp_resp_d;
      rd_rsp_data  <= rd_rsp_data_d;
      if (rf_pop) ARADDR <= rf_addr[rf_rptr[PW-1:0]];
    end
  end

`ifdef AXIM_STATS_EN
  // Counters advance on the same edge that raises the response pulse, saturating at all-ones.
  logic [1:0] err_inc;
  assign err_inc = 2'(wr_rsp_valid_d && wr_rsp_resp_d[1]) + 2'(rd_rsp_valid_d && rd_rsp_resp_d[1]);

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = 17'(c) + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      wr_count  <= sat_add(wr_count, 2'(wr_rsp_valid_d));
      rd_count  <= sat_add(rd_count, 2'(rd_rsp_valid_d));
      err_count <= sat_add(err_count, err_inc);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_master_q.sv
// Directed self-checking bench for axi4_lite_master_q (default parameters, CMD_DEPTH=4).
module tb_axi4_lite_master_q;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [3:0] wr_req_strb;
  logic wr_rsp_valid;
  logic [1:0] wr_rsp_resp;
  logic rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [1:0] rd_rsp_resp;
  logic [ADDR_W-1:0] AWADDR;
  logic AWVALID, AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [3:0] WSTRB;
  logic WVALID, WREADY;
  logic [1:0] BRESP;
  logic BVALID, BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic ARVALID, ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0] RRESP;
  logic RVALID, RREADY;
`ifdef AXIM_STATS_EN
  logic [15:0] wr_count, rd_count, err_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_q #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_resp(wr_rsp_resp),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_resp(rd_rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXIM_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
  );

  // Advance to just after the next rising edge; inputs set here are sampled on the following edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of request traffic on either or both request ports.
  task automatic applyStimulus(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic rv, input logic [31:0] ra);
    wr_req_valid = wv;
    wr_req_addr  = wa;
    wr_req_data  = wd;
    wr_req_strb  = ws;
    rd_req_valid = rv;
    rd_req_addr  = ra;
    tick();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
  endtask

  task automatic waitAwValid();
    for (int i = 0; i < 20 && !AWVALID; i++) tick();
    checkOutput("aw_wait", AWVALID, 1);
  endtask

  initial begin
    ARESETN = 1'b0;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_data = 0; wr_req_strb = 0;
    rd_req_valid = 0; rd_req_addr = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;

    // Reset state
    tick(); tick();
    checkOutput("rst_awvalid", AWVALID, 0);
    checkOutput("rst_arvalid", ARVALID, 0);
    checkOutput("rst_bready", BREADY, 0);
    checkOutput("rst_rready", RREADY, 0);
    checkOutput("rst_wr_ready", wr_req_ready, 0);
    checkOutput("rst_rsp", {wr_rsp_valid, rd_rsp_valid}, 0);
    ARESETN = 1'b1;
    tick();
    checkOutput("rel_wr_ready", wr_req_ready, 1);
    checkOutput("rel_rd_ready", rd_req_ready, 1);

    // Single write, both ready together, OKAY
    applyStimulus(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    checkOutput("sw_cyc1_awvalid", AWVALID, 0);
    tick();
    checkOutput("sw_awvalid", AWVALID, 1);
    checkOutput("sw_wvalid", WVALID, 1);
    checkOutput("sw_awaddr", AWADDR, 32'h10);
    checkOutput("sw_wdata", WDATA, 32'hDEADBEEF);
    checkOutput("sw_wstrb", WSTRB, 4'hF);
    tick();
    checkOutput("sw_hold_awaddr", AWADDR, 32'h10);
    checkOutput("sw_hold_wdata", WDATA, 32'hDEADBEEF);
    AWREADY = 1; WREADY = 1;
    tick();
    AWREADY = 0; WREADY = 0;
    checkOutput("sw_valids_drop", {AWVALID, WVALID}, 0);
    checkOutput("sw_bready", BREADY, 1);
    BVALID = 1; BRESP = 2'b00;
    tick();
    BVALID = 0;
    checkOutput("sw_rsp_valid", wr_rsp_valid, 1);
    checkOutput("sw_rsp_resp", wr_rsp_resp, 2'b00);
    checkOutput("sw_bready_drop", BREADY, 0);
    tick();
    checkOutput("sw_rsp_pulse_end", wr_rsp_valid, 0);

    // Split handshake: W three cycles ahead of AW
    applyStimulus(1, 32'h30, 32'hA5A5A5A5, 4'h3, 0, 0);
    tick();
    checkOutput("sp_awvalid", AWVALID, 1);
    WREADY = 1;
    tick();
    WREADY = 0;
    checkOutput("sp_wvalid_drop", WVALID, 0);
    checkOutput("sp_aw_hold", AWVALID, 1);
    checkOutput("sp_bready_early", BREADY, 0);
    tick(); tick();
    checkOutput("sp_aw_hold2", AWVALID, 1);
    checkOutput("sp_awaddr_hold", AWADDR, 32'h30);
    checkOutput("sp_bready_early2", BREADY, 0);
    AWREADY = 1;
    tick();
    AWREADY = 0;
    checkOutput("sp_aw_drop", AWVALID, 0);
    checkOutput("sp_bready", BREADY, 1);
    BVALID = 1; BRESP = 2'b01;
    tick();
    BVALID = 0;
    checkOutput("sp_rsp", {wr_rsp_valid, wr_rsp_resp}, 3'b101);
    tick();
    checkOutput("sp_single_rsp", wr_rsp_valid, 0);

    // FIFO full: five writes with the slave stalled
    for (int i = 0; i < 5; i++) begin
      checkOutput("ff_ready_before", wr_req_ready, 1);
      applyStimulus(1, 32'h100 + 32'(i) * 4, 32'h10000000 + 32'(i), 4'hF, 0, 0);
    end
    checkOutput("ff_full", wr_req_ready, 0);
    tick();
    checkOutput("ff_still_full", wr_req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      waitAwValid();
      checkOutput("ff_awaddr", AWADDR, 32'h100 + 32'(i) * 4);
      checkOutput("ff_wdata", WDATA, 32'h10000000 + 32'(i));
      AWREADY = 1; WREADY = 1;
      tick();
      AWREADY = 0; WREADY = 0;
      checkOutput("ff_bready", BREADY, 1);
      BVALID = 1; BRESP = 2'b00;
      tick();
      BVALID = 0;
      checkOutput("ff_rsp", wr_rsp_valid, 1);
    end
    checkOutput("ff_ready_after", wr_req_ready, 1);
    tick();
    checkOutput("ff_drained", AWVALID, 0);

    // Read with SLVERR
    applyStimulus(0, 0, 0, 0, 1, 32'h20);
    tick();
    checkOutput("rd_arvalid", ARVALID, 1);
    checkOutput("rd_araddr", ARADDR, 32'h20);
    checkOutput("rd_rready_early", RREADY, 0);
    ARREADY = 1;
    tick();
    ARREADY = 0;
    checkOutput("rd_ar_drop", ARVALID, 0);
    checkOutput("rd_rready", RREADY, 1);
    RVALID = 1; RDATA = 32'h12345678; RRESP = 2'b10;
    tick();
    RVALID = 0;
    checkOutput("rd_rsp_valid", rd_rsp_valid, 1);
    checkOutput("rd_rsp_data", rd_rsp_data, 32'h12345678);
    checkOutput("rd_rsp_resp", rd_rsp_resp, 2'b10);
    checkOutput("rd_rready_drop", RREADY, 0);
`ifdef AXIM_STATS_EN
    checkOutput("st_err1", err_count, 1);
    checkOutput("st_wr", wr_count, 7);
    checkOutput("st_rd", rd_count, 1);
`endif
    tick();

    // Concurrent read and write issued in the same cycle
    applyStimulus(1, 32'h50, 32'h0BADF00D, 4'hC, 1, 32'h40);
    tick();
    checkOutput("cc_both_valid", {AWVALID, ARVALID}, 2'b11);
    checkOutput("cc_araddr", ARADDR, 32'h40);
    checkOutput("cc_awaddr", AWADDR, 32'h50);
    ARREADY = 1;
    tick();
    ARREADY = 0;
    RVALID = 1; RDATA = 32'hCAFEF00D; RRESP = 2'b00;
    tick();
    RVALID = 0;
    checkOutput("cc_rd_rsp", {rd_rsp_valid, rd_rsp_data}, {1'b1, 32'hCAFEF00D});
    checkOutput("cc_no_wr_rsp", wr_rsp_valid, 0);
    checkOutput("cc_aw_pending", AWVALID, 1);
    AWREADY = 1; WREADY = 1;
    tick();
    AWREADY = 0; WREADY = 0;
    BVALID = 1; BRESP = 2'b11;
    tick();
    BVALID = 0;
    checkOutput("cc_wr_rsp", {wr_rsp_valid, wr_rsp_resp}, 3'b111);
    checkOutput("cc_no_rd_rsp", rd_rsp_valid, 0);
`ifdef AXIM_STATS_EN
    checkOutput("st_err2", err_count, 2);
`endif
    tick();

    // Reset while waiting for read data, with a second read still queued
    applyStimulus(0, 0, 0, 0, 1, 32'h60);
    applyStimulus(0, 0, 0, 0, 1, 32'h64);
    checkOutput("mr_arvalid", ARVALID, 1);
    ARREADY = 1;
    tick();
    ARREADY = 0;
    checkOutput("mr_rready", RREADY, 1);
    ARESETN = 0;
    RVALID = 1; RDATA = 32'h55AA55AA;
    #1;
    checkOutput("mr_rready_async", RREADY, 0);
    checkOutput("mr_rd_ready", rd_req_ready, 0);
    tick();
    checkOutput("mr_no_pulse_rst", rd_rsp_valid, 0);
    RVALID = 0;
    ARESETN = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mr_quiet", {ARVALID, RREADY, rd_rsp_valid}, 0);
    end
    checkOutput("mr_ready_back", rd_req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
